// File: rtl/wb_commit_stage.sv
// wb_commit_stage
// Final pipeline stage: holds one instruction from MEM for a single cycle,
// drives the register-file write port and the trace-probe commit record,
// counts retired instructions and detects halt (ebreak / illegal) and hang
// (no retirement within WDOG cycles).
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | normal operation, accepting instructions
// HALT  | ebreak retired or illegal instruction committed; terminal
// HANG  | watchdog expired without a retirement; terminal
module wb_commit_stage #(
  parameter logic [63:0] DEV_LO = 64'h0000_0000_a000_0000,
  parameter logic [63:0] DEV_HI = 64'h0000_0000_afff_ffff,
  parameter int unsigned WDOG   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [63:0] in_dnpc,
  input  logic        in_mem_en,
  input  logic [63:0] in_mem_addr,
  input  logic        in_invalid,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_wen,
  input  logic [63:0] in_rd_data,
  input  logic        flush,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic [31:0] commit_inst,
  output logic [63:0] commit_dnpc,
  output logic        commit_kill,
  output logic        commit_invalid,
  output logic        commit_device,
  output logic        commit_en,
  output logic        halt,
  output logic        hang,
  output logic [63:0] instret
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam int unsigned WD_W = (WDOG > 1) ? $clog2(WDOG) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG - 1);

  typedef enum logic [1:0] {RUN, HALT, HANG} state_t;

  state_t          state;
  logic [WD_W-1:0] wdog_cnt;
  logic            accept;
  logic            retire;
  logic            halt_cond;
  logic            hang_cond;
  logic            load;
  logic            dev_hit;

  assign in_ready = (state == RUN);
  assign halt     = (state == HALT);
  assign hang     = (state == HANG);

  assign accept  = in_valid && in_ready;
  assign retire  = commit_en && !commit_kill && !commit_invalid;
  assign dev_hit = in_mem_en && (in_mem_addr >= DEV_LO) && (in_mem_addr <= DEV_HI);

  // Halt takes priority over hang; both are evaluated on the held entry.
  assign halt_cond = (state == RUN) && commit_en && !commit_kill &&
                     (commit_invalid || (commit_inst == EBREAK));
  assign hang_cond = (state == RUN) && !retire && (wdog_cnt == WD_LAST);

  // An instruction accepted on the edge that leaves RUN is dropped, so no
  // commit record ever appears while halted or hung.
  assign load = accept && !halt_cond && !hang_cond;

  // Pipeline register: commit record and register-file write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_en      <= 1'b0;
      commit_kill    <= 1'b0;
      commit_invalid <= 1'b0;
      commit_device  <= 1'b0;
      commit_inst    <= '0;
      commit_dnpc    <= '0;
      rf_wen         <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
    end else begin
      commit_en      <= load;
      commit_kill    <= load && flush;
      commit_invalid <= load && in_invalid;
      commit_device  <= load && dev_hit;
      rf_wen         <= load && !flush && !in_invalid && in_rd_wen && (in_rd != 5'd0);
      if (load) begin
        commit_inst <= in_inst;
        commit_dnpc <= in_dnpc;
        rf_waddr    <= in_rd;
        rf_wdata    <= in_rd_data;
      end
    end
  end

  // Run/halt/hang FSM with retirement counter and watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      instret  <= '0;
      wdog_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (retire) begin
            instret  <= instret + 64'd1;
            wdog_cnt <= '0;
          end else begin
            wdog_cnt <= wdog_cnt + WD_W'(1);
          end
          if (halt_cond) begin
            state <= HALT;
          end else if (hang_cond) begin
            state <= HANG;
          end
        end
        HALT:    state <= HALT;
        HANG:    state <= HANG;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage: scoreboard of expected commit records, one task
// per scenario, small watchdog so hang timing is exercised quickly.
module tb_wb_commit_stage;

  localparam logic [63:0] DEV_LO = 64'h0000_0000_a000_0000;
  localparam logic [63:0] DEV_HI = 64'h0000_0000_afff_ffff;
  localparam int unsigned WDOG   = 16;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ADDI1  = 32'h0050_0093;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_dnpc;
  logic        in_mem_en;
  logic [63:0] in_mem_addr;
  logic        in_invalid;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [63:0] in_rd_data;
  logic        flush;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [31:0] commit_inst;
  logic [63:0] commit_dnpc;
  logic        commit_kill;
  logic        commit_invalid;
  logic        commit_device;
  logic        commit_en;
  logic        halt;
  logic        hang;
  logic [63:0] instret;

  wb_commit_stage #(.DEV_LO(DEV_LO), .DEV_HI(DEV_HI), .WDOG(WDOG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_dnpc(in_dnpc), .in_mem_en(in_mem_en),
    .in_mem_addr(in_mem_addr), .in_invalid(in_invalid), .in_rd(in_rd),
    .in_rd_wen(in_rd_wen), .in_rd_data(in_rd_data), .flush(flush),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit_inst(commit_inst), .commit_dnpc(commit_dnpc),
    .commit_kill(commit_kill), .commit_invalid(commit_invalid),
    .commit_device(commit_device), .commit_en(commit_en),
    .halt(halt), .hang(hang), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic        kill;
    logic        inv;
    logic        dev;
    logic [31:0] inst;
    logic [63:0] dnpc;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
  } rec_t;

  rec_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_instret = '0;

  function automatic rec_t observed();
    rec_t r;
    r = {commit_en, commit_kill, commit_invalid, commit_device, commit_inst,
         commit_dnpc, rf_wen, rf_waddr, rf_wdata};
    return r;
  endfunction

  task automatic idle();
    in_valid    = 1'b0;
    flush       = 1'b0;
    in_inst     = '0;
    in_dnpc     = '0;
    in_mem_en   = 1'b0;
    in_mem_addr = '0;
    in_invalid  = 1'b0;
    in_rd       = '0;
    in_rd_wen   = 1'b0;
    in_rd_data  = '0;
  endtask

  // Drive one offered instruction and push the record the stage must show.
  task automatic offer(input logic [31:0] inst, input logic [63:0] dnpc,
                       input logic mem_en, input logic [63:0] addr,
                       input logic inv, input logic [4:0] rd, input logic wen,
                       input logic [63:0] data, input logic fl);
    rec_t e;
    in_valid = 1'b1; in_inst = inst; in_dnpc = dnpc; in_mem_en = mem_en;
    in_mem_addr = addr; in_invalid = inv; in_rd = rd; in_rd_wen = wen;
    in_rd_data = data; flush = fl;
    e.en    = 1'b1;
    e.kill  = fl;
    e.inv   = inv;
    e.dev   = mem_en && (addr >= DEV_LO) && (addr <= DEV_HI);
    e.inst  = inst;
    e.dnpc  = dnpc;
    e.wen   = !fl && !inv && wen && (rd != 5'd0);
    e.waddr = rd;
    e.wdata = data;
    exp_q.push_back(e);
    if (!fl && !inv) exp_instret = exp_instret + 64'd1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_instret = '0;
  endtask

  task automatic test_reset();
    idle();
    in_valid = 1'b1;
    in_inst  = ADDI1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (observed() !== rec_t'(0)) begin n_err++; $display("FAIL reset_record got=%h exp=0", observed()); end
    n_vec++; if (instret !== 64'd0) begin n_err++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    n_vec++; if ({halt, hang} !== 2'b00) begin n_err++; $display("FAIL reset_halt_hang got=%b exp=00", {halt, hang}); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
    idle();
    exp_q.delete();
    exp_instret = '0;
  endtask

  task automatic test_addi();
    rec_t e;
    do_reset();
    offer(ADDI1, 64'h8000_0004, 1'b0, '0, 1'b0, 5'd1, 1'b1, 64'd5, 1'b0);
    @(posedge clk); #1;
    idle();
    e = exp_q.pop_front();
    n_vec++; if (observed() !== e) begin n_err++; $display("FAIL addi_record got=%h exp=%h", observed(), e); end
    n_vec++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 64'd5}) begin n_err++; $display("FAIL addi_rf got=%b/%0d/%0d exp=1/1/5", rf_wen, rf_waddr, rf_wdata); end
    @(posedge clk); #1;
    n_vec++; if (instret !== 64'd1) begin n_err++; $display("FAIL addi_instret got=%0d exp=1", instret); end
    n_vec++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL addi_single_cycle got=%b exp=0", commit_en); end
  endtask

  task automatic test_flush();
    rec_t e;
    do_reset();
    offer(ADDI1, 64'h8000_0004, 1'b0, '0, 1'b0, 5'd1, 1'b1, 64'd5, 1'b1);
    @(posedge clk); #1;
    idle();
    e = exp_q.pop_front();
    n_vec++; if (observed() !== e) begin n_err++; $display("FAIL flush_record got=%h exp=%h", observed(), e); end
    n_vec++; if ({commit_en, commit_kill, rf_wen} !== 3'b110) begin n_err++; $display("FAIL flush_flags got=%b exp=110", {commit_en, commit_kill, rf_wen}); end
    flush = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (instret !== 64'd0) begin n_err++; $display("FAIL flush_instret got=%0d exp=0", instret); end
    n_vec++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL flush_no_accept got=%b exp=0", commit_en); end
    // killed ebreak and killed illegal must not halt
    offer(EBREAK, 64'h8000_0010, 1'b0, '0, 1'b0, 5'd0, 1'b0, '0, 1'b1);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_vec++; if (observed() !== e) begin n_err++; $display("FAIL flush_ebreak got=%h exp=%h", observed(), e); end
    offer(32'hffff_ffff, 64'h8000_0014, 1'b0, '0, 1'b1, 5'd2, 1'b1, 64'd9, 1'b1);
    @(posedge clk); #1;
    idle();
    e = exp_q.pop_front();
    n_vec++; if (observed() !== e) begin n_err++; $display("FAIL flush_illegal got=%h exp=%h", observed(), e); end
    @(posedge clk); #1;
    n_vec++; if ({halt, in_ready, instret} !== {1'b0, 1'b1, 64'd0}) begin n_err++; $display("FAIL flush_no_halt got halt=%b ready=%b instret=%0d exp 0/1/0", halt, in_ready, instret); end
  endtask

  task automatic test_device();
    logic [63:0] addrs[7];
    logic        ens[7];
    logic        devs[7];
    rec_t        e;
    addrs = '{64'ha000_03f8, 64'h8000_0000, DEV_LO, DEV_HI, DEV_LO - 64'd1, DEV_HI + 64'd1, 64'ha000_0100};
    ens   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    devs  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      offer(32'h00b5_3023, 64'h8000_0100 + 64'(i * 4), ens[i], addrs[i], 1'b0, 5'd0, 1'b0, '0, 1'b0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_vec++; if (commit_device !== devs[i]) begin n_err++; $display("FAIL device_%0d addr=%h got=%b exp=%b", i, addrs[i], commit_device, devs[i]); end
      n_vec++; if (observed() !== e) begin n_err++; $display("FAIL device_rec_%0d got=%h exp=%h", i, observed(), e); end
    end
    idle();
    @(posedge clk); #1;
    n_vec++; if (instret !== 64'd7) begin n_err++; $display("FAIL device_instret got=%0d exp=7", instret); end
  endtask

  task automatic test_back_to_back();
    rec_t        e;
    logic [31:0] inst;
    logic [63:0] addr;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3) != 0) begin
        inst = $urandom();
        if (inst == EBREAK) inst = 32'h0000_0013;
        addr = ($urandom_range(1) != 0) ? DEV_LO + 64'($urandom_range(255)) : 64'h8000_0000 + 64'($urandom_range(255));
        offer(inst, {$urandom(), $urandom()}, 1'($urandom_range(1)), addr, 1'b0,
              5'($urandom_range(31)), 1'($urandom_range(1)), {$urandom(), $urandom()},
              $urandom_range(3) == 0);
      end else begin
        idle();
      end
      @(posedge clk); #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++; if (observed() !== e) begin n_err++; $display("FAIL b2b_record_%0d got=%h exp=%h", i, observed(), e); end
      end else begin
        n_vec++; if ({commit_en, rf_wen} !== 2'b00) begin n_err++; $display("FAIL b2b_idle_%0d got=%b exp=00", i, {commit_en, rf_wen}); end
      end
    end
    idle();
    @(posedge clk); #1;
    n_vec++; if (instret !== exp_instret) begin n_err++; $display("FAIL b2b_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_halt();
    rec_t e;
    do_reset();
    offer(ADDI1, 64'h8000_0004, 1'b0, '0, 1'b0, 5'd1, 1'b1, 64'd5, 1'b0);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_vec++; if (observed() !== e) begin n_err++; $display("FAIL halt_pre got=%h exp=%h", observed(), e); end
    offer(EBREAK, 64'h8000_0008, 1'b0, '0, 1'b0, 5'd0, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_vec++; if (observed() !== e) begin n_err++; $display("FAIL halt_ebreak got=%h exp=%h", observed(), e); end
    in_inst = ADDI1; in_rd = 5'd3; in_rd_wen = 1'b1;
    @(posedge clk); #1;
    n_vec++; if ({halt, hang, in_ready, commit_en} !== 4'b1000) begin n_err++; $display("FAIL halt_state got=%b exp=1000", {halt, hang, in_ready, commit_en}); end
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if ({commit_en, rf_wen, halt} !== 3'b001) begin n_err++; $display("FAIL halt_ignore got=%b exp=001", {commit_en, rf_wen, halt}); end
    n_vec++; if (instret !== 64'd2) begin n_err++; $display("FAIL halt_instret got=%0d exp=2", instret); end
    do_reset();
    n_vec++; if ({halt, in_ready} !== 2'b01) begin n_err++; $display("FAIL halt_reset got=%b exp=01", {halt, in_ready}); end
    offer(32'hffff_ffff, 64'h8000_0004, 1'b0, '0, 1'b1, 5'd3, 1'b1, 64'd7, 1'b0);
    @(posedge clk); #1;
    idle();
    e = exp_q.pop_front();
    n_vec++; if (observed() !== e) begin n_err++; $display("FAIL illegal_record got=%h exp=%h", observed(), e); end
    @(posedge clk); #1;
    n_vec++; if ({halt, instret} !== {1'b1, 64'd0}) begin n_err++; $display("FAIL illegal_halt got halt=%b instret=%0d exp 1/0", halt, instret); end
  endtask

  task automatic test_hang();
    rec_t e;
    do_reset();
    repeat (15) @(posedge clk);
    #1;
    n_vec++; if ({hang, in_ready} !== 2'b01) begin n_err++; $display("FAIL hang_early got=%b exp=01", {hang, in_ready}); end
    in_valid = 1'b1; in_inst = ADDI1; in_rd = 5'd1; in_rd_wen = 1'b1;
    @(posedge clk); #1;
    n_vec++; if ({hang, halt, in_ready, commit_en} !== 4'b1000) begin n_err++; $display("FAIL hang_16 got=%b exp=1000", {hang, halt, in_ready, commit_en}); end
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if ({hang, commit_en, rf_wen} !== 3'b100) begin n_err++; $display("FAIL hang_terminal got=%b exp=100", {hang, commit_en, rf_wen}); end
    // retirement presented in the 16th idle cycle rescues the watchdog
    do_reset();
    repeat (14) @(posedge clk);
    #1;
    offer(ADDI1, 64'h8000_0004, 1'b0, '0, 1'b0, 5'd1, 1'b1, 64'd5, 1'b0);
    @(posedge clk); #1;
    idle();
    e = exp_q.pop_front();
    n_vec++; if (observed() !== e) begin n_err++; $display("FAIL hang_rescue_rec got=%h exp=%h", observed(), e); end
    @(posedge clk); #1;
    n_vec++; if ({hang, instret} !== {1'b0, 64'd1}) begin n_err++; $display("FAIL hang_rescue got hang=%b instret=%0d exp 0/1", hang, instret); end
    repeat (14) @(posedge clk);
    #1;
    n_vec++; if (hang !== 1'b0) begin n_err++; $display("FAIL hang_restart_early got=%b exp=0", hang); end
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (hang !== 1'b1) begin n_err++; $display("FAIL hang_restart got=%b exp=1", hang); end
    // a killed entry does not feed the watchdog
    do_reset();
    repeat (14) @(posedge clk);
    #1;
    offer(ADDI1, 64'h8000_0004, 1'b0, '0, 1'b0, 5'd1, 1'b1, 64'd5, 1'b1);
    @(posedge clk); #1;
    idle();
    e = exp_q.pop_front();
    n_vec++; if (observed() !== e) begin n_err++; $display("FAIL hang_kill_rec got=%h exp=%h", observed(), e); end
    @(posedge clk); #1;
    n_vec++; if ({hang, instret} !== {1'b1, 64'd0}) begin n_err++; $display("FAIL hang_kill got hang=%b instret=%0d exp 1/0", hang, instret); end
  endtask

  task automatic test_reset_mid();
    rec_t e;
    do_reset();
    offer(ADDI1, 64'h8000_0004, 1'b0, '0, 1'b0, 5'd1, 1'b1, 64'd5, 1'b0);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_vec++; if (observed() !== e) begin n_err++; $display("FAIL mid_held got=%h exp=%h", observed(), e); end
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_instret = '0;
    n_vec++; if ({commit_en, rf_wen, halt, hang, in_ready} !== 5'b00001) begin n_err++; $display("FAIL mid_flags got=%b exp=00001", {commit_en, rf_wen, halt, hang, in_ready}); end
    n_vec++; if (instret !== 64'd0) begin n_err++; $display("FAIL mid_instret got=%0d exp=0", instret); end
    @(posedge clk); #1;
    n_vec++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL mid_no_pulse got=%b exp=0", commit_en); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_addi();
    test_flush();
    test_device();
    test_back_to_back();
    test_halt();
    test_hang();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_commit_stage.md
WB_COMMIT_STAGE -- requirements
Module: wb_commit_stage

Interface
REQ-001 Parameters: DEV_LO, default 64'h0000_0000_a000_0000, lowest device (MMIO) address, inclusive.
REQ-002 Parameters: DEV_HI, default 64'h0000_0000_afff_ffff, highest device address, inclusive.
REQ-003 Parameters: WDOG, default 1024, number of cycles without a retired instruction before a hang is declared.
REQ-004 Reset rst, synchronous, active-high; clock clk.
REQ-005 Ports: clk  in  1  clock (all state on posedge).
REQ-006 Ports: rst  in  1  synchronous active-high reset.
REQ-007 Ports: in_valid  in  1  MEM stage offers an instruction.
REQ-008 Ports: in_ready  out  1  stage accepts this cycle.
REQ-009 Ports: in_inst  in  32  instruction word.
REQ-010 Ports: in_dnpc  in  64  next PC after this instruction.
REQ-011 Ports: in_mem_en  in  1  instruction performed a load or store.
REQ-012 Ports: in_mem_addr  in  64  load/store address.
REQ-013 Ports: in_invalid  in  1  decoder flagged an illegal instruction.
REQ-014 Ports: in_rd, in_rd_wen, in_rd_data  in  5/1/64  destination register, write enable, write data.
REQ-015 Ports: flush  in  1  kill the instruction accepted this cycle.
REQ-016 Ports: rf_wen, rf_waddr, rf_wdata  out  1/5/64  register file write port.
REQ-017 Ports: commit_inst, commit_dnpc  out  32/64  retired record, fed to the trace probe.
REQ-018 Ports: commit_kill, commit_invalid, commit_device, commit_en  out  1 each  retired record flags, fed to the trace probe.
REQ-019 Ports: halt, hang  out  1 each  simulation stop conditions.
REQ-020 Ports: instret  out  64  count of retired, non-killed instructions.

Function
REQ-021 Single-entry pipeline register; an input is accepted when in_valid && in_ready, and all outputs are driven from registers.
REQ-022 FSM states RUN, HALT, HANG; in_ready = (state==RUN).
REQ-023 Latency 1: an instruction accepted at edge N is presented on commit_* and rf_* during the cycle after edge N, for exactly one cycle, unless another instruction is accepted at edge N+1.
REQ-024 commit_en = 1 in every cycle the register holds an entry, including killed entries; it is 0 otherwise.
REQ-025 commit_kill = flush sampled at the accepting edge; flush with no accept has no effect.
REQ-026 commit_device = in_mem_en && DEV_LO <= in_mem_addr <= DEV_HI (unsigned, 64-bit, both ends inclusive).
REQ-027 commit_invalid = in_invalid; commit_inst and commit_dnpc are copies of the accepted fields.
REQ-028 rf_wen = entry && !kill && !invalid && rd_wen && rd != 0; rf_waddr and rf_wdata are the registered values.
REQ-029 An entry is retired when it is present, not killed and not invalid; each retirement increments instret by 1, and instret wraps modulo 2^64.
REQ-030 RUN -> HALT when a retired entry has inst == 32'h0010_0073 (ebreak), or when a non-killed entry has invalid = 1; the transition occurs at the edge after the entry is presented.
REQ-031 Watchdog counter: cleared on each retirement and on rst, incremented otherwise in RUN; RUN -> HANG when the counter reaches WDOG-1 without a retirement.
REQ-032 halt = (state==HALT) and hang = (state==HANG); HALT and HANG are terminal until rst.
REQ-033 No input is accepted in HALT or HANG; in those states commit_en = 0 and rf_wen = 0.
REQ-034 Killed entries do not update instret and do not clear the watchdog.
REQ-035 If HALT and HANG conditions arise in the same cycle, HALT wins.

Reset
REQ-036 While rst is high at an edge: state = RUN, entry cleared, all commit_* = 0, rf_* = 0, instret = 0, watchdog = 0, halt = 0, hang = 0.
REQ-037 rst asserted mid-operation discards the held entry with no commit_en pulse; in_ready = 1 in the first cycle after rst deasserts.

Verification
REQ-038 Accept addi x1 (rd=1, data=5) at edge N -> at N+1: commit_en = 1, rf_wen = 1, rf_waddr = 1, rf_wdata = 5, and instret increments by 1.
REQ-039 Accept with flush = 1 -> commit_en = 1, commit_kill = 1, rf_wen = 0, instret unchanged.
REQ-040 Store to 64'ha000_03f8 -> commit_device = 1; store to 64'h8000_0000 -> commit_device = 0; addresses DEV_LO and DEV_HI -> commit_device = 1.
REQ-041 Accept 32'h0010_0073 -> commit_en for one cycle, then halt = 1 and in_ready = 0; a subsequent in_valid is ignored.
REQ-042 With WDOG = 16, no retirement for 16 cycles -> hang = 1; retirement at cycle 15 -> hang stays 0.
REQ-043 Assert rst while an entry is held -> next cycle: commit_en = 0, instret = 0, halt = 0, hang = 0, in_ready = 1.
